program_memory_loader: RTL and testbench

//  256x8 program/data RAM that the Mock8080 CPU core fetches from and stores to (data_addr/data_out/write_en -> cpu_*).

---
 rtl/mock8080_pkg.sv | 6 +
 rtl/mem_array_sp.sv | 20 ++
 rtl/program_memory_loader.sv | 105 ++++++++++
 tb/tb_program_memory_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mock8080_pkg.sv
// mock8080_pkg: shared widths and loader FSM state encodings for the Mock8080 memory slice.
package mock8080_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, HOLD = 2'd2, RUN = 2'd3} state_t;
endpackage

// File: rtl/mem_array_sp.sv
// mem_array_sp: single-port synchronous RAM, read-first, with a resettable read register that holds when re is low.
module mem_array_sp #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_qzt,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  input  logic          re,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk_qzt) begin
    if (we) mem[addr] <= wdata;
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/program_memory_loader.sv
// program_memory_loader: Mock8080 program RAM with host byte loader and CPU start sequencing.
// Define LOADER_CHECKSUM_EN to accumulate a mod-256 checksum of loaded bytes on ld_checksum.
module program_memory_loader
  import mock8080_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_qzt,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              run_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_en,
  output logic              cpu_reset,
  output logic [ADDR_W-1:0] cpu_res_addr,
  output logic [DATA_W-1:0] ld_checksum
);
  localparam int CNT_W = ADDR_W + 1;
  state_t state_q;
  logic [ADDR_W-1:0] ptr_q, res_addr_q, mem_addr;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] mem_wdata;
  logic ld_ready_q, ld_done_q, cpu_en_q, cpu_reset_q;
  logic start_ok, len_zero, xfer, mem_we, in_run;
  assign in_run   = state_q == RUN;
  assign start_ok = ld_start && state_q != LOAD;
  assign len_zero = ld_len == '0;
  assign xfer     = state_q == LOAD && ld_valid && ld_ready_q;
  always_comb begin
    mem_addr  = in_run ? cpu_addr : ptr_q;
    mem_wdata = in_run ? cpu_wdata : ld_data;
    mem_we    = !reset && (xfer || (in_run && cpu_we));
  end
  // res_addr is base-1 because the CPU loads PC <= res_addr + 1 on reset release
  always_ff @(posedge clk_qzt) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      res_addr_q  <= '0;
      ld_ready_q  <= 1'b0;
      ld_done_q   <= 1'b0;
      cpu_en_q    <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      ld_done_q <= 1'b0;
      if (start_ok) begin
        state_q     <= len_zero ? HOLD : LOAD;
        ptr_q       <= ld_base;
        cnt_q       <= ld_len;
        res_addr_q  <= ld_base - ADDR_W'(1);
        ld_ready_q  <= !len_zero;
        ld_done_q   <= len_zero;
        cpu_en_q    <= len_zero;
        cpu_reset_q <= 1'b1;
      end else if (xfer) begin
        ptr_q <= ptr_q + ADDR_W'(1);
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_q    <= HOLD;
          ld_ready_q <= 1'b0;
          ld_done_q  <= 1'b1;
          cpu_en_q   <= 1'b1;
        end
      end else if (state_q == HOLD && run_req) begin
        state_q     <= RUN;
        cpu_reset_q <= 1'b0;
      end
    end
  end
  mem_array_sp #(.AW(ADDR_W), .DW(DATA_W)) u_mem (
    .clk_qzt(clk_qzt),
    .reset  (reset),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .we     (mem_we),
    .re     (in_run),
    .rdata  (cpu_rdata)
  );
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
  always_ff @(posedge clk_qzt) begin
    if (reset || start_ok) sum_q <= '0;
    else if (xfer) sum_q <= sum_q + ld_data;
  end
  assign ld_checksum = sum_q;
`else
  assign ld_checksum = '0;
`endif
  assign ld_ready     = ld_ready_q;
  assign ld_done      = ld_done_q;
  assign cpu_en       = cpu_en_q;
  assign cpu_reset    = cpu_reset_q;
  assign cpu_res_addr = res_addr_q;
endmodule

// File: tb/tb_program_memory_loader.sv
// tb_program_memory_loader: directed self-checking bench for program_memory_loader.
module tb_program_memory_loader;
  logic clk_qzt = 1'b0;
  logic reset = 1'b1;
  logic ld_start = 1'b0;
  logic [7:0] ld_base = '0;
  logic [8:0] ld_len = '0;
  logic ld_valid = 1'b0;
  logic [7:0] ld_data = '0;
  logic ld_ready, ld_done;
  logic run_req = 1'b0;
  logic [7:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic cpu_we = 1'b0;
  logic [7:0] cpu_rdata;
  logic cpu_en, cpu_reset;
  logic [7:0] cpu_res_addr, ld_checksum;
  int total = 0;
  int bad = 0;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [7:0] SUM1 = 8'h30;
  localparam logic [7:0] SUM6 = 8'h10;
`else
  localparam logic [7:0] SUM1 = 8'h00;
  localparam logic [7:0] SUM6 = 8'h00;
`endif

  program_memory_loader dut (
    .clk_qzt(clk_qzt), .reset(reset),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .ld_done(ld_done),
    .run_req(run_req),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_rdata(cpu_rdata),
    .cpu_en(cpu_en), .cpu_reset(cpu_reset), .cpu_res_addr(cpu_res_addr),
    .ld_checksum(ld_checksum)
  );

  always #5 clk_qzt = ~clk_qzt;

  task automatic tick();
    @(posedge clk_qzt);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [7:0] b, input logic [8:0] l);
    ld_start = 1'b1;
    ld_base = b;
    ld_len = l;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    ld_valid = 1'b1;
    ld_data = d;
    tick();
    ld_valid = 1'b0;
    ld_data = 8'hEE;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] e);
    cpu_addr = a;
    tick();
    chk(tag, cpu_rdata, e);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_en", cpu_en, 0);
    chk("rst_cpureset", cpu_reset, 1);
    chk("rst_resaddr", cpu_res_addr, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_sum", ld_checksum, 0);
    reset = 1'b0;
    tick();
    // basic load of three bytes at 0x10
    start(8'h10, 9'd3);
    chk("t1_ready", ld_ready, 1);
    chk("t1_en_load", cpu_en, 0);
    send(8'h06);
    chk("t1_done_early", ld_done, 0);
    send(8'h2A);
    send(8'h00);
    chk("t1_done", ld_done, 1);
    chk("t1_ready_drop", ld_ready, 0);
    chk("t1_en_hold", cpu_en, 1);
    chk("t1_cpureset_hold", cpu_reset, 1);
    chk("t1_resaddr", cpu_res_addr, 8'h0F);
    chk("t1_sum", ld_checksum, SUM1);
    tick();
    chk("t1_done_pulse", ld_done, 0);
    // ld_start beats a simultaneous run_req in HOLD; stalled beats do not count
    run_req = 1'b1;
    start(8'h20, 9'd2);
    run_req = 1'b0;
    chk("t2_start_wins", ld_ready, 1);
    chk("t2_cpureset", cpu_reset, 1);
    ld_data = 8'hEE;
    tick();
    chk("t2_stall_ready", ld_ready, 1);
    send(8'h11);
    tick();
    chk("t2_stall_done", ld_done, 0);
    send(8'h22);
    chk("t2_done", ld_done, 1);
    chk("t2_resaddr", cpu_res_addr, 8'h1F);
    // pointer wrap
    start(8'hFE, 9'd4);
    send(8'h0A);
    send(8'h0B);
    send(8'h0C);
    chk("t3_mid_done", ld_done, 0);
    send(8'h0D);
    chk("t3_done", ld_done, 1);
    chk("t3_resaddr", cpu_res_addr, 8'hFD);
    // zero-length load
    start(8'h30, 9'd0);
    chk("t4_done", ld_done, 1);
    chk("t4_ready", ld_ready, 0);
    chk("t4_resaddr", cpu_res_addr, 8'h2F);
    tick();
    chk("t4_done_pulse", ld_done, 0);
    chk("t4_ready2", ld_ready, 0);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("run_cpureset", cpu_reset, 0);
    chk("run_en", cpu_en, 1);
    rd("m10", 8'h10, 8'h06);
    rd("m11", 8'h11, 8'h2A);
    rd("m12", 8'h12, 8'h00);
    rd("m20", 8'h20, 8'h11);
    rd("m21", 8'h21, 8'h22);
    rd("mFE", 8'hFE, 8'h0A);
    rd("mFF", 8'hFF, 8'h0B);
    rd("m00", 8'h00, 8'h0C);
    rd("m01", 8'h01, 8'h0D);
    // CPU write then read, then read-first on collision
    cpu_addr = 8'h40;
    cpu_wdata = 8'h5A;
    cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    rd("t5_rd", 8'h40, 8'h5A);
    cpu_we = 1'b1;
    cpu_wdata = 8'h77;
    tick();
    cpu_we = 1'b0;
    chk("t5_readfirst", cpu_rdata, 8'h5A);
    rd("t5_newdata", 8'h40, 8'h77);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    chk("t5_runreq_ign", cpu_reset, 0);
    // abort run, CPU writes and ld_start ignored in LOAD, reset after two bytes
    start(8'h50, 9'd5);
    chk("t6_abort_en", cpu_en, 0);
    chk("t6_abort_rst", cpu_reset, 1);
    chk("t6_rdata_hold", cpu_rdata, 8'h77);
    cpu_addr = 8'h40;
    cpu_wdata = 8'h99;
    cpu_we = 1'b1;
    send(8'h80);
    ld_start = 1'b1;
    ld_base = 8'h70;
    ld_len = 9'd1;
    send(8'h90);
    ld_start = 1'b0;
    cpu_we = 1'b0;
    chk("t6_sum", ld_checksum, SUM6);
    chk("t6_still_load", ld_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_rst_done", ld_done, 0);
    chk("t6_rst_ready", ld_ready, 0);
    chk("t6_rst_sum", ld_checksum, 0);
    tick();
    chk("t6_no_done", ld_done, 0);
    start(8'h60, 9'd0);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    rd("t6_m50", 8'h50, 8'h80);
    rd("t6_m51", 8'h51, 8'h90);
    rd("t6_m40", 8'h40, 8'h77);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
